// File: rtl/gcm_in_seq.sv
// gcm_in_seq -- front-end sequencer for the gcm core.
//
// Takes one command per message (IV, AAD block count, payload block count).
// It pulses iv_en and then key_expanded. It then hands gcm the length block,
// the AAD blocks and the payload blocks over a valid/ready handshake. Finally
// it counts gcm_op_done results and waits for gcm_tag_done before retiring
// the message with a one-cycle done pulse.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_iv, cmd_aad_blks,
//   cmd_pld_blks               per-message IV and block counts
//   s_data/s_valid/s_ready     AAD + payload block stream in
//   iv, iv_en, key_expanded    gcm configuration outputs
//   gcm_in_blk/gcm_valid/
//   gcm_ready                  block stream out to gcm
//   gcm_op_done, gcm_tag_done  result events from gcm
//   busy, done, pld_out_cnt    status
//
// Build option: define GCM_SEQ_SKID_EN to put a 2-entry skid buffer between
// s_* and the output register. s_ready then comes from a register and has
// no combinational path from gcm_ready.
module gcm_in_seq #(
    parameter int BLK_BITS = 128,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [BLK_BITS-1:0] cmd_iv,
    input  logic [CNT_BITS-1:0] cmd_aad_blks,
    input  logic [CNT_BITS-1:0] cmd_pld_blks,
    input  logic [BLK_BITS-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [BLK_BITS-1:0] iv,
    output logic                iv_en,
    output logic                key_expanded,
    output logic [BLK_BITS-1:0] gcm_in_blk,
    output logic                gcm_valid,
    input  logic                gcm_ready,
    input  logic                gcm_op_done,
    input  logic                gcm_tag_done,
    output logic                busy,
    output logic                done,
    output logic [CNT_BITS-1:0] pld_out_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_IV, S_KEY, S_LEN, S_AAD, S_PLD, S_WAIT, S_DONE
    } state_t;

    state_t              r_state;
    logic [BLK_BITS-1:0] r_iv;
    logic [BLK_BITS-1:0] r_out;
    logic                r_gcm_valid;
    logic [CNT_BITS-1:0] r_aad_blks;
    logic [CNT_BITS-1:0] r_pld_blks;
    logic [CNT_BITS-1:0] r_pld_out_cnt;
    logic [CNT_BITS:0]   r_hs_cnt;     // data handshakes so far (AAD + payload)
    logic                r_tag_seen;
    logic                r_iv_en;
    logic                r_key_exp;
    logic                r_done;

    logic                w_gcm_hs;
    logic                w_data_phase;
    logic                w_s_ready;
    logic                w_src_valid;
    logic [BLK_BITS-1:0] w_src_data;
    logic                w_take;
    logic                w_load;
    logic [CNT_BITS:0]   w_hs_inc;
    logic [CNT_BITS:0]   w_total;
    logic [BLK_BITS-1:0] w_len_blk;

    assign w_gcm_hs     = r_gcm_valid && gcm_ready;
    assign w_data_phase = (r_state == S_AAD) || (r_state == S_PLD);
    assign w_hs_inc     = r_hs_cnt + 1'b1;
    assign w_total      = {1'b0, r_aad_blks} + {1'b0, r_pld_blks};
    // Bit lengths of AAD and payload: each count times 128, in a 64-bit field.
    assign w_len_blk    = {64'(r_aad_blks) << 7, 64'(r_pld_blks) << 7};

    // The output register may take a new block when it is empty or is being
    // drained this cycle.
    assign w_take = !r_gcm_valid || gcm_ready;
    assign w_load = w_src_valid && w_take && (r_state != S_KEY);

`ifdef GCM_SEQ_SKID_EN
    logic [BLK_BITS-1:0] r_fb0;
    logic [BLK_BITS-1:0] r_fb1;
    logic [1:0]          r_fcnt;
    logic                r_not_full;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_fcnt_nxt;

    assign w_s_ready   = w_data_phase && r_not_full;
    assign w_push      = s_valid && w_s_ready;
    assign w_pop       = w_load;
    assign w_src_valid = (r_fcnt != 2'd0);
    assign w_src_data  = r_fb0;
    assign w_fcnt_nxt  = r_fcnt + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fcnt     <= 2'd0;
            r_not_full <= 1'b1;
        end else begin
            r_fcnt     <= w_fcnt_nxt;
            r_not_full <= (w_fcnt_nxt != 2'd2);
        end
    end

    // r_fb0 is the head. A push into a full buffer cannot happen because
    // s_ready is already low once two entries are held.
    always_ff @(posedge clk) begin
        if (w_pop && (r_fcnt == 2'd2))
            r_fb0 <= r_fb1;
        else if (w_push && ((r_fcnt == 2'd0) || w_pop))
            r_fb0 <= s_data;
        if (w_push && !w_pop && (r_fcnt == 2'd1))
            r_fb1 <= s_data;
    end
`else
    assign w_s_ready   = w_data_phase && (!r_gcm_valid || gcm_ready);
    assign w_src_valid = s_valid && w_data_phase;
    assign w_src_data  = s_data;
`endif

    // Output register. The length block is loaded on the KEY->LEN step. After
    // that, stream blocks are loaded. Once valid, a block stays put until gcm
    // accepts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out       <= '0;
            r_gcm_valid <= 1'b0;
        end else if (r_state == S_KEY) begin
            r_out       <= w_len_blk;
            r_gcm_valid <= 1'b1;
        end else if (w_load) begin
            r_out       <= w_src_data;
            r_gcm_valid <= 1'b1;
        end else if (w_gcm_hs) begin
            r_gcm_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_iv          <= '0;
            r_aad_blks    <= '0;
            r_pld_blks    <= '0;
            r_pld_out_cnt <= '0;
            r_hs_cnt      <= '0;
            r_tag_seen    <= 1'b0;
            r_iv_en       <= 1'b0;
            r_key_exp     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_iv_en   <= 1'b0;
            r_key_exp <= 1'b0;
            r_done    <= 1'b0;

            // Result events are recorded in every active state. Payload
            // results saturate at the message's payload count.
            if (r_state != S_IDLE) begin
                if (gcm_op_done && (r_pld_out_cnt != r_pld_blks))
                    r_pld_out_cnt <= r_pld_out_cnt + 1'b1;
                if (gcm_tag_done)
                    r_tag_seen <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_iv          <= cmd_iv;
                        r_aad_blks    <= cmd_aad_blks;
                        r_pld_blks    <= cmd_pld_blks;
                        r_pld_out_cnt <= '0;
                        r_tag_seen    <= 1'b0;
                        r_iv_en       <= 1'b1;
                        r_state       <= S_IV;
                    end
                end
                S_IV: begin
                    r_key_exp <= 1'b1;
                    r_state   <= S_KEY;
                end
                S_KEY: r_state <= S_LEN;
                S_LEN: begin
                    if (w_gcm_hs) begin
                        r_hs_cnt <= '0;
                        if (r_aad_blks != '0)      r_state <= S_AAD;
                        else if (r_pld_blks != '0) r_state <= S_PLD;
                        else                       r_state <= S_WAIT;
                    end
                end
                S_AAD: begin
                    if (w_gcm_hs) begin
                        r_hs_cnt <= w_hs_inc;
                        if (w_hs_inc == {1'b0, r_aad_blks})
                            r_state <= (r_pld_blks != '0) ? S_PLD : S_WAIT;
                    end
                end
                S_PLD: begin
                    if (w_gcm_hs) begin
                        r_hs_cnt <= w_hs_inc;
                        if (w_hs_inc == w_total)
                            r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if ((r_pld_out_cnt == r_pld_blks) && r_tag_seen) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // cmd_ready is gated by reset so it reads low while reset is held.
    assign cmd_ready    = (r_state == S_IDLE) && !reset;
    assign s_ready      = w_s_ready;
    assign iv           = r_iv;
    assign iv_en        = r_iv_en;
    assign key_expanded = r_key_exp;
    assign gcm_in_blk   = r_out;
    assign gcm_valid    = r_gcm_valid;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign pld_out_cnt  = r_pld_out_cnt;

endmodule
